// File: rtl/mem_access_unit.sv
// mem_access_unit: sequenced memory-bus master serialising fetch, read and write requests
// with hit/timeout completion, IR/MDR capture and a sticky timeout error flag.
module mem_access_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic              clk_100,
    input  logic              rst,
    input  logic              req_fetch,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [ADDR_W-1:0] mar_addr,
    input  logic [DATA_W-1:0] mdr_wdata,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] address_out,
    output logic [DATA_W-1:0] memory_out,
    output logic              memory_write_en,
    input  logic [DATA_W-1:0] memory_in,
    input  logic              hit,
    output logic [DATA_W-1:0] ir_out,
    output logic [DATA_W-1:0] mdr_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, FETCH, READ, WRITE} state_t;
    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] mem_nx, ir_nx, mdr_nx;
    logic              we_nx, busy_nx, done_nx, err_nx, last;
    // address_out/memory_out double as the latched address and write data while busy
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        addr_nx  = address_out;
        mem_nx   = memory_out;
        we_nx    = memory_write_en;
        busy_nx  = busy;
        done_nx  = 1'b0;
        err_nx   = err & ~err_clr;
        ir_nx    = ir_out;
        mdr_nx   = mdr_rdata;
        last     = cnt == CNT_W'(TIMEOUT - 1);
        if (state == IDLE) begin
            if (req_write || req_read || req_fetch) begin
                state_nx = req_write ? WRITE : req_read ? READ : FETCH;
                addr_nx  = req_fetch && !req_write && !req_read ? pc_addr : mar_addr;
                mem_nx   = req_write ? mdr_wdata : '0;
                we_nx    = req_write;
                busy_nx  = 1'b1;
                cnt_nx   = '0;
            end
        end else if (hit || last) begin
            state_nx = IDLE;
            addr_nx  = '0;
            mem_nx   = '0;
            we_nx    = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            ir_nx    = hit && state == FETCH ? memory_in : ir_out;
            mdr_nx   = hit && state == READ ? memory_in : mdr_rdata;
            err_nx   = hit ? err_nx : 1'b1;
        end else begin
            cnt_nx = &cnt ? cnt : cnt + 1'b1;
        end
    end
    always_ff @(posedge clk_100) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            address_out     <= '0;
            memory_out      <= '0;
            memory_write_en <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            ir_out          <= '0;
            mdr_rdata       <= '0;
        end else begin
            state           <= state_nx;
            cnt             <= cnt_nx;
            address_out     <= addr_nx;
            memory_out      <= mem_nx;
            memory_write_en <= we_nx;
            busy            <= busy_nx;
            done            <= done_nx;
            err             <= err_nx;
            ir_out          <= ir_nx;
            mdr_rdata       <= mdr_nx;
        end
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised memory-bus front end for the microcoded processor.
- Replaces the per-signal tri-state address/data muxing with one sequenced master that serialises three request types from the control unit: instruction fetch, data read and data write.
- Holds an access until the memory/cache returns `hit`, or until a timeout expires.
- Delivers the fetched instruction word to IR and read data to MDR, with a one-cycle `done` pulse.

Parameters:
- DATA_W, 16, data bus and register width.
- ADDR_W, 16, address bus width.
- TIMEOUT, 15, maximum access cycles without `hit` before abort; legal range 1..255.
- CNT_W, 8, wait-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_100  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- req_fetch  in  1  instruction fetch request (control bit 0 equivalent).
- req_read  in  1  data read request.
- req_write  in  1  data write request.
- pc_addr  in  ADDR_W  fetch address from PC.
- mar_addr  in  ADDR_W  data address from MAR.
- mdr_wdata  in  DATA_W  write data from MDR.
- err_clr  in  1  clears the sticky `err` flag.
- address_out  out  ADDR_W  memory address; 0 when idle.
- memory_out  out  DATA_W  write data; 0 unless in WRITE.
- memory_write_en  out  1  memory write strobe.
- memory_in  in  DATA_W  memory read data; valid when `hit`=1.
- hit  in  1  memory/cache completion for the current access.
- ir_out  out  DATA_W  last fetched instruction.
- mdr_rdata  out  DATA_W  last read data word.
- busy  out  1  access in progress.
- done  out  1  one-cycle completion pulse (success or timeout).
- err  out  1  sticky timeout flag.

Behaviour:
- **Reset.** While `rst`=1 at a clock edge, all of the following are cleared on that edge, regardless of state (including mid-access): state=IDLE; address_out, memory_out, ir_out, mdr_rdata = 0; memory_write_en, busy, done, err = 0; wait counter = 0.
- **FSM states.** IDLE, FETCH, READ, WRITE.
- **IDLE.** Requests are sampled only here.
  - Priority: write > read > fetch when more than one request is high.
  - On an accepted request, the next edge latches the address (pc_addr for fetch, mar_addr otherwise) and, for writes, mdr_wdata.
  - The same edge enters the target state, sets busy=1 and clears the counter.
  - Requests arriving while busy=1 are ignored; the control unit holds its request until it sees `done`.
- **Access states (FETCH, READ, WRITE).**
  - address_out drives the latched address.
  - In WRITE, memory_out drives the latched data and memory_write_en=1 every cycle until exit.
  - In FETCH and READ, memory_write_en=0 and memory_out=0.
  - The counter increments on each access cycle without `hit`.
- **Hit.** `hit` is sampled on each access-state cycle, including the first. On a hit, the next edge:
  - FETCH: ir_out ← memory_in.
  - READ: mdr_rdata ← memory_in.
  - WRITE: no capture.
  - In all cases: done=1, busy=0, memory_write_en=0, address_out=0, memory_out=0, state=IDLE.
- **Latency.** Request high at edge N−1 → access cycle from edge N. Zero-wait hit in that cycle → done and data visible from edge N+1. Each miss cycle adds 1 cycle.
- **Timeout.**
  - Exit occurs on the access cycle where counter == TIMEOUT−1 and hit=0. The next edge sets err=1, done=1, busy=0 and returns to IDLE.
  - ir_out and mdr_rdata are left unchanged.
  - The access therefore lasts exactly TIMEOUT cycles.
- **Hit on the final allowed cycle.** A hit on cycle TIMEOUT−1 counts as success: err is not set.
- **done.** Pulses for exactly one cycle. A new request present on the done cycle (state already IDLE) is accepted at that edge, so back-to-back accesses have no dead cycle beyond the done cycle.
- **err.**
  - Sticky; cleared by err_clr=1 at an edge or by rst.
  - If a timeout and err_clr occur on the same edge, err ends at 1 (set wins).
- **hit in IDLE.** Ignored.
- **Widths.** No arithmetic on data. The counter saturates and never wraps.

Test Plan:
- **Fetch, zero-wait.** rst 2 cycles; req_fetch=1, pc_addr=0x0001, hit=1 with memory_in=0xA3F0 in the first access cycle → address_out=0x0001 for 1 cycle, ir_out=0xA3F0 and done=1 next cycle, busy low after that.
- **Write with waits.** req_write=1, mar_addr=0x0040, mdr_wdata=0x1234; hit on 3rd access cycle → memory_write_en=1 for exactly 3 cycles with address_out=0x0040 and memory_out=0x1234; done one cycle later; mdr_rdata unchanged.
- **Priority.** req_fetch=req_read=req_write=1 simultaneously → WRITE taken first. Holding req_read and req_fetch afterwards → READ next, FETCH last, each separated by one done cycle.
- **Timeout.** TIMEOUT=15, req_read, hit held 0 → access lasts 15 cycles, then err=1 and done=1, mdr_rdata unchanged. Next, err_clr=1 → err=0. Repeat with hit on cycle 15 → err stays 0 and data is captured.
- **Reset mid-write.** rst asserted on 2nd WRITE cycle → next edge memory_write_en=0, busy=0, address_out=0, state IDLE; a subsequent fetch completes normally.
- **Back-to-back fetches with hit=1 held.** → a new access starts on each done cycle; done pulses every 2 cycles; ir_out tracks each memory_in.
